// File: rtl/bcd_convert.sv
// Sequential binary-to-BCD converter (shift-and-add-3, MSB first) with sign
// handling, sticky overflow saturation and leading-zero blanking.
module bcd_convert #(
  parameter int DIN_W    = 24,
  parameter int NDIG     = 6,
  parameter int FRAC_DIG = 4,
  parameter int BLANK_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,     // active-high asynchronous reset
  input  logic                  din_vld,
  output logic                  din_rdy,
  input  logic                  din_sign,
  input  logic [DIN_W-1:0]      din,
  output logic                  dout_vld,
  output logic                  dout_sign,
  output logic [4*NDIG-1:0]     dout,
  output logic                  dout_ovf,
  output logic [1:0]            dbg_state
);

  localparam int ACC_W = 4 * NDIG;
  localparam int CNT_W = $clog2(DIN_W + 1);

  // Handshake: a word transfers on a rising edge where din_vld && din_rdy.
  // din_rdy is high only in IDLE; the source must hold din/din_sign until then.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DIN_W-1:0]   r_sr;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic               r_ovf;

  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_result;
  logic               w_zero;
  logic               w_accept;
  logic               w_last_shift;

  assign din_rdy      = (r_state == IDLE);
  assign dbg_state    = r_state;
  assign w_accept     = (r_state == IDLE) && din_vld;
  assign w_last_shift = (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (din_vld) w_next = SHIFT;
      SHIFT:   if (w_last_shift) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Add-3 correction on every digit of 5 or more before the doubling shift
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < NDIG; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // Output formatting: saturate on overflow, otherwise blank leading zeros
  // down to (but never including) the units digit.
  always_comb begin
    logic lead;
    lead     = 1'b1;
    w_result = r_acc;
    w_zero   = (r_acc == '0) && !r_ovf;
    if (r_ovf) begin
      w_result = {NDIG{4'h9}};
    end else if (BLANK_EN != 0) begin
      for (int k = NDIG - 1; k > FRAC_DIG; k--) begin
        if (lead && (r_acc[4*k +: 4] == 4'd0)) begin
          w_result[4*k +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
    end
  end

  // Conversion datapath
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_sr   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sr   <= din;
            r_sign <= din_sign;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= CNT_W'(DIN_W);
          end
        end
        SHIFT: begin
          // Accumulator and shift register move as one concatenation; the bit
          // leaving the top digit is lost magnitude, hence sticky overflow.
          {r_acc, r_sr} <= {w_adj[ACC_W-2:0], r_sr, 1'b0};
          r_ovf         <= r_ovf | w_adj[ACC_W-1];
          r_cnt         <= r_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers hold until the next DONE edge
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dout      <= '0;
      dout_sign <= 1'b0;
      dout_ovf  <= 1'b0;
      dout_vld  <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      if (r_state == DONE) begin
        dout      <= w_result;
        dout_sign <= r_sign & ~w_zero;
        dout_ovf  <= r_ovf;
        dout_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_convert.sv
// Directed bench for bcd_convert: default instance plus a BLANK_EN=0 instance
// sharing the same stimulus.
module tb_bcd_convert;

  logic        clk;
  logic        rst_n;
  logic        din_vld;
  logic        din_sign;
  logic [23:0] din;

  logic        din_rdy,  dout_vld,  dout_sign,  dout_ovf;
  logic [23:0] dout;
  logic [1:0]  dbg_state;
  logic        nb_rdy,   nb_vld,    nb_sign,    nb_ovf;
  logic [23:0] nb_dout;
  logic [1:0]  nb_state;

  int n_checks;
  int n_fail;

  bcd_convert dut (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din_rdy(din_rdy),
    .din_sign(din_sign), .din(din), .dout_vld(dout_vld), .dout_sign(dout_sign),
    .dout(dout), .dout_ovf(dout_ovf), .dbg_state(dbg_state)
  );

  bcd_convert #(.BLANK_EN(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din_rdy(nb_rdy),
    .din_sign(din_sign), .din(din), .dout_vld(nb_vld), .dout_sign(nb_sign),
    .dout(nb_dout), .dout_ovf(nb_ovf), .dbg_state(nb_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors: din, sign, expected dout, sign, ovf, and BLANK_EN=0 dout
  logic [23:0] v_din  [8] = '{24'd253125, 24'd5000, 24'd0, 24'hFFFFFF,
                              24'd7, 24'd10000, 24'd1000000, 24'd999999};
  logic        v_sign [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [23:0] e_dout [8] = '{24'h253125, 24'hF05000, 24'hF00000, 24'h999999,
                              24'hF00007, 24'hF10000, 24'h999999, 24'h999999};
  logic        e_sign [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        e_ovf  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [23:0] e_nb   [8] = '{24'h253125, 24'h005000, 24'h000000, 24'h999999,
                              24'h000007, 24'h010000, 24'h999999, 24'h999999};

  // Driver: one transfer, then wait (bounded) for the result strobe.
  // lat counts rising edges after the accepting edge.
  task automatic run_conv(input logic [23:0] d, input logic s, output int lat);
    @(negedge clk);
    din      = d;
    din_sign = s;
    din_vld  = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    lat = 0;
    while (!dout_vld && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    din_vld = 1'b1;
    din     = 24'd42;
    din_sign = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dout !== 24'h0 || dout_sign !== 1'b0 || dout_ovf !== 1'b0 || dout_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h sign=%b ovf=%b vld=%b, want 000000 0 0 0",
               dout, dout_sign, dout_ovf, dout_vld);
    end
    n_checks++;
    if (din_rdy !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got rdy=%b state=%0d, want rdy=1 state=0", din_rdy, dbg_state);
    end
    din_vld = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (din_rdy !== 1'b1 || dout_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want 1 0", din_rdy, dout_vld);
    end
  endtask

  task automatic test_vectors();
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_conv(v_din[i], v_sign[i], lat);
      n_checks++;
      if (lat !== 25) begin
        n_fail++;
        $display("FAIL latency[%0d]: got %0d edges, want 25", i, lat);
      end
      n_checks++;
      if (dout !== e_dout[i] || dout_sign !== e_sign[i] || dout_ovf !== e_ovf[i]) begin
        n_fail++;
        $display("FAIL result[%0d] din=%0d: got dout=%h sign=%b ovf=%b, want %h %b %b",
                 i, v_din[i], dout, dout_sign, dout_ovf, e_dout[i], e_sign[i], e_ovf[i]);
      end
      n_checks++;
      if (nb_vld !== 1'b1 || nb_dout !== e_nb[i]) begin
        n_fail++;
        $display("FAIL noblank[%0d]: got vld=%b dout=%h, want 1 %h", i, nb_vld, nb_dout, e_nb[i]);
      end
      // Strobe lasts one cycle and results hold afterwards
      repeat (2) @(negedge clk);
      n_checks++;
      if (dout_vld !== 1'b0 || dout !== e_dout[i] || dout_ovf !== e_ovf[i]) begin
        n_fail++;
        $display("FAIL hold[%0d]: got vld=%b dout=%h ovf=%b, want 0 %h %b",
                 i, dout_vld, dout, dout_ovf, e_dout[i], e_ovf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    din      = 24'd1;
    din_sign = 1'b0;
    din_vld  = 1'b1;
    @(negedge clk);
    din = 24'd999999;
    n = 0;
    while (!din_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== 25) begin
      n_fail++;
      $display("FAIL b2b_busy: got rdy low %0d cycles, want 25", n);
    end
    n_checks++;
    if (dout_vld !== 1'b1 || dout !== 24'hF00001 || dout_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got vld=%b dout=%h ovf=%b, want 1 f00001 0", dout_vld, dout, dout_ovf);
    end
    @(negedge clk);
    n = 0;
    while (!dout_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    din_vld = 1'b0;
    n_checks++;
    if (n !== 25) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d edges, want 25", n);
    end
    n_checks++;
    if (dout !== 24'h999999 || dout_ovf !== 1'b0 || dout_sign !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got dout=%h ovf=%b sign=%b, want 999999 0 0", dout, dout_ovf, dout_sign);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int bad;
    int lat;
    @(negedge clk);
    din      = 24'd777777;
    din_sign = 1'b1;
    din_vld  = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    repeat (9) @(negedge clk);
    rst_n   = 1'b1;
    din_vld = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dout !== 24'h0 || dout_sign !== 1'b0 || dout_ovf !== 1'b0 || dout_vld !== 1'b0 || din_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reset: got dout=%h sign=%b ovf=%b vld=%b rdy=%b, want 000000 0 0 0 1",
               dout, dout_sign, dout_ovf, dout_vld, din_rdy);
    end
    @(negedge clk);
    din_vld = 1'b0;
    rst_n   = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (dout_vld !== 1'b0 || din_rdy !== 1'b1 || dout !== 24'h0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d bad cycles, want 0", bad);
    end
    run_conv(24'd123456, 1'b0, lat);
    n_checks++;
    if (lat !== 25 || dout !== 24'h123456 || dout_ovf !== 1'b0 || dout_sign !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next: got lat=%0d dout=%h ovf=%b sign=%b, want 25 123456 0 0",
               lat, dout, dout_ovf, dout_sign);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    din_vld  = 1'b0;
    din_sign = 1'b0;
    din      = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_convert.md
BCD_CONVERT -- requirements
Module: bcd_convert

Interface
REQ-001 Parameters:
- DIN_W, 24, width of the unsigned magnitude input.
- NDIG, 6, number of BCD output digits.
- FRAC_DIG, 4, digits right of the decimal point; SHALL satisfy 0 <= FRAC_DIG < NDIG.
- BLANK_EN, 1, enables leading-zero blanking.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: asynchronous reset, ACTIVE-HIGH; asserted when 1, despite the name.
- din_vld, in, 1: input valid.
- din_rdy, out, 1: converter idle, input accepted.
- din_sign, in, 1: sign flag of input (1 = negative).
- din, in, DIN_W: unsigned magnitude.
- dout_vld, out, 1: one-cycle result strobe.
- dout_sign, out, 1: registered result sign.
- dout, out, 4*NDIG: BCD digits; digit k is at [4k+3:4k], digit 0 least significant.
- dout_ovf, out, 1: magnitude did not fit in NDIG digits.

REQ-003 The block SHALL use a single clock domain; reset is asynchronous assert, active-high.

Function
REQ-004 FSM SHALL have states IDLE, SHIFT and DONE.
- Reset state: IDLE.
- din_rdy = 1 exactly when state == IDLE.

REQ-005 Handshake: a transfer occurs on a rising edge with state IDLE and din_vld = 1.
- That edge captures din into the shift register and din_sign.
- The same edge clears the BCD accumulator and the overflow flag, loads the bit counter with DIN_W, and moves to SHIFT.

REQ-006 SHIFT, one input bit per edge, MSB first:
- Every accumulator digit >= 5 SHALL have 3 added.
- The accumulator and shift register then shift left by 1 as a single concatenation.
- The counter decrements.
- After DIN_W shift edges, the FSM moves to DONE.

REQ-007 Any 1 shifted out of the top accumulator digit SHALL set a sticky overflow flag.

REQ-008 DONE lasts one edge. That edge SHALL register dout, dout_sign, dout_ovf, pulse dout_vld high for one cycle, and return to IDLE.

REQ-009 Latency is fixed regardless of data:
- dout_vld is registered at edge T+DIN_W+1 after accepting edge T.
- din_rdy is low for exactly DIN_W+1 cycles.
- Throughput is one conversion per DIN_W+2 cycles when din_vld is held high.

REQ-010 din_vld while din_rdy = 0 SHALL be ignored. No buffering; the source holds data until accepted.

REQ-011 Overflow: if the sticky flag is set, dout SHALL be all digits 9, dout_ovf = 1, and no blanking SHALL be applied.

REQ-012 Blanking, BLANK_EN = 1 and no overflow:
- Scan digits NDIG-1 down to FRAC_DIG+1; each zero digit with all higher digits zero SHALL output 4'hF.
- The units digit (index FRAC_DIG) and all fraction digits SHALL never be blanked.
- With BLANK_EN = 0, raw digits are output.

REQ-013 Negative zero: if the converted magnitude is zero, dout_sign SHALL be 0 regardless of din_sign. Otherwise dout_sign = captured din_sign.

REQ-014 dout, dout_sign and dout_ovf SHALL hold their last value until the next DONE edge.

Reset
REQ-015 While rst_n = 1:
- State = IDLE.
- dout = 0, dout_sign = 0, dout_ovf = 0, dout_vld = 0.
- Accumulator, shift register and counter = 0.
- din_vld is ignored.

REQ-016 Reset asserted mid-SHIFT or in DONE SHALL abort the conversion with no dout_vld pulse. The first transfer after release starts a clean conversion.

Verification (defaults DIN_W = 24, NDIG = 6, FRAC_DIG = 4, BLANK_EN = 1)
REQ-017 din = 253125, sign 0 -> dout = 0x253125, dout_ovf 0, dout_sign 0; dout_vld at edge T+25, single cycle.

REQ-018 din = 5000, sign 1 -> dout = 0xF05000, dout_sign 1. With BLANK_EN = 0 -> dout = 0x005000.

REQ-019 din = 0, sign 1 -> dout = 0xF00000, dout_sign 0.

REQ-020 din = 16777215 (0xFFFFFF) -> dout = 0x999999, dout_ovf 1. A following din = 7 SHALL give dout = 0xF00007 with dout_ovf 0.

REQ-021 din_vld held high, din = 1 then 999999:
- din_rdy is low 25 cycles between transfers.
- Second transfer on the first din_rdy = 1 cycle.
- Results 0xF00001 then 0x999999 with dout_ovf 0.

REQ-022 rst_n pulsed high at shift edge 10 -> no dout_vld, all outputs 0, din_rdy = 1 after release; next din = 123456 -> 0x123456.
